// File: rtl/avalon_spi_host_master.sv
// Avalon-MM initiator that turns single-beat local commands into read/write
// transfers, with waitrequest timeout and an irq-triggered data-register fetch.
module avalon_spi_host_master #(
    parameter int                ADDR_W       = 8,
    parameter int                DATA_W       = 32,
    parameter int                READ_LATENCY = 1,
    parameter int                TIMEOUT      = 255,
    parameter logic [ADDR_W-1:0] DATA_ADDR    = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_error,
    output logic              rsp_fetch,
    output logic              av_chipselect,
    output logic              av_read,
    output logic              av_write,
    output logic [ADDR_W-1:0] av_address,
    output logic [DATA_W-1:0] av_writedata,
    input  logic [DATA_W-1:0] av_readdata,
    input  logic              av_waitrequest,
    input  logic              irq,
    input  logic              auto_fetch_en
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_DATA = 2'd2;
    localparam logic [1:0] S_RESP      = 2'd3;

    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] LCNT_INIT = 3'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    logic [1:0] state;
    logic       irq_q;
    logic       fetch_pending;
    logic       is_fetch;
    logic       lat_write;
    logic [7:0] tcnt;
    logic [2:0] lcnt;
    logic       irq_rise;
    logic       fetch_start;

    assign cmd_ready   = (state == S_IDLE) & ~fetch_pending;
    assign irq_rise    = irq & ~irq_q;
    assign fetch_start = (state == S_IDLE) & fetch_pending;

    // NOTE: all state uses non-blocking assignments and async reset so strobes drop the instant reset_n falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q         <= 1'b0;
            fetch_pending <= 1'b0;
        end else begin
            irq_q <= irq;
            // A fresh edge wins over the clear so a back-to-back interrupt is not lost.
            if (irq_rise && auto_fetch_en)
                fetch_pending <= 1'b1;
            else if (fetch_start)
                fetch_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            is_fetch      <= 1'b0;
            lat_write     <= 1'b0;
            tcnt          <= '0;
            lcnt          <= '0;
            av_chipselect <= 1'b0;
            av_read       <= 1'b0;
            av_write      <= 1'b0;
            av_address    <= '0;
            av_writedata  <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_error     <= 1'b0;
            rsp_fetch     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fetch_pending) begin
                        is_fetch   <= 1'b1;
                        lat_write  <= 1'b0;
                        av_address <= DATA_ADDR;
                        tcnt       <= '0;
                        state      <= S_ISSUE;
                    end else if (cmd_valid && cmd_ready) begin
                        is_fetch     <= 1'b0;
                        lat_write    <= cmd_write;
                        av_address   <= cmd_addr;
                        av_writedata <= cmd_wdata;
                        tcnt         <= '0;
                        state        <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // First ISSUE cycle launches the strobes; waitrequest only matters once they are up.
                    if (!av_chipselect) begin
                        av_chipselect <= 1'b1;
                        av_read       <= ~lat_write;
                        av_write      <= lat_write;
                    end else if (av_waitrequest) begin
                        if (tcnt == TCNT_LAST) begin
                            av_chipselect <= 1'b0;
                            av_read       <= 1'b0;
                            av_write      <= 1'b0;
                            rsp_valid     <= 1'b1;
                            rsp_data      <= '0;
                            rsp_error     <= 1'b1;
                            rsp_fetch     <= is_fetch;
                            state         <= S_RESP;
                        end else begin
                            tcnt <= tcnt + 8'd1;
                        end
                    end else begin
                        av_chipselect <= 1'b0;
                        av_read       <= 1'b0;
                        av_write      <= 1'b0;
                        if (lat_write) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            rsp_error <= 1'b0;
                            rsp_fetch <= is_fetch;
                            state     <= S_RESP;
                        end else if (READ_LATENCY == 0) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= av_readdata;
                            rsp_error <= 1'b0;
                            rsp_fetch <= is_fetch;
                            state     <= S_RESP;
                        end else begin
                            lcnt  <= LCNT_INIT;
                            state <= S_WAIT_DATA;
                        end
                    end
                end

                S_WAIT_DATA: begin
                    if (lcnt == 3'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= av_readdata;
                        rsp_error <= 1'b0;
                        rsp_fetch <= is_fetch;
                        state     <= S_RESP;
                    end else begin
                        lcnt <= lcnt - 3'd1;
                    end
                end

                S_RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
